// File: rtl/raw_hazard_unit.sv
// Decode-stage RAW hazard detector for a 5-stage pipeline without forwarding.
// A 3-entry scoreboard shadows the destination registers of the instructions in
// EX, MEM and WB. A consumer in ID that reads a pending destination is held in
// IF/ID while a NOP is inserted into ID/EX.
// Optional build macro RAW_RF_BYPASS_EN: the register file writes before it reads,
// so the WB entry is excluded from the hit terms. The WB entry is still tracked.
module raw_hazard_unit #(
  parameter int unsigned REG_W = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic             id_uses_rs,
  input  logic             id_match_both,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_writes_reg,
  input  logic [REG_W-1:0] id_rd,
  input  logic             mem_busy,
  input  logic             ex_flush,
  output logic             stall,
  output logic             bubble,
  output logic [1:0]       hz_state,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    StRun  = 2'd0,
    StRaw  = 2'd1,
    StHold = 2'd2
  } hz_state_e;

  hz_state_e state_q, state_d;

  logic             sb_ex_v_q,  sb_ex_v_d;
  logic             sb_mem_v_q, sb_mem_v_d;
  logic             sb_wb_v_q,  sb_wb_v_d;
  logic [REG_W-1:0] sb_ex_rd_q,  sb_ex_rd_d;
  logic [REG_W-1:0] sb_mem_rd_q, sb_mem_rd_d;
  logic [REG_W-1:0] sb_wb_rd_q,  sb_wb_rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic rs_hit, rt_hit, raw;
  logic wb_rs_hit, wb_rt_hit;

  // WB-stage comparison; dropped when the register file bypasses write-to-read.
`ifdef RAW_RF_BYPASS_EN
  assign wb_rs_hit = 1'b0;
  assign wb_rt_hit = 1'b0;
`else
  assign wb_rs_hit = sb_wb_v_q & (sb_wb_rd_q == id_rs);
  assign wb_rt_hit = sb_wb_v_q & (sb_wb_rd_q == id_rt);
`endif

  // Hit terms against every live scoreboard entry; Rt only counts for two-source ops.
  always_comb begin
    rs_hit = id_uses_rs & ((sb_ex_v_q & (sb_ex_rd_q == id_rs)) |
                           (sb_mem_v_q & (sb_mem_rd_q == id_rs)) |
                           wb_rs_hit);
    rt_hit = id_match_both & ((sb_ex_v_q & (sb_ex_rd_q == id_rt)) |
                              (sb_mem_v_q & (sb_mem_rd_q == id_rt)) |
                              wb_rt_hit);
    raw    = id_valid & ~ex_flush & (rs_hit | rt_hit);
  end

  // Control outputs are forced low while reset is asserted, even if memory is busy.
  assign stall  = rst_n & (raw | mem_busy);
  assign bubble = rst_n & raw & ~mem_busy;

  // Scoreboard shift; a busy memory freezes the whole pipe, including flush effects.
  always_comb begin
    sb_ex_v_d   = sb_ex_v_q;
    sb_ex_rd_d  = sb_ex_rd_q;
    sb_mem_v_d  = sb_mem_v_q;
    sb_mem_rd_d = sb_mem_rd_q;
    sb_wb_v_d   = sb_wb_v_q;
    sb_wb_rd_d  = sb_wb_rd_q;
    if (!mem_busy) begin
      sb_wb_v_d   = sb_mem_v_q;
      sb_wb_rd_d  = sb_mem_rd_q;
      sb_mem_v_d  = sb_ex_v_q;
      sb_mem_rd_d = sb_ex_rd_q;
      sb_ex_v_d   = id_valid & id_writes_reg & ~raw & ~ex_flush;
      sb_ex_rd_d  = id_rd;
    end
  end

  // Status FSM; lags the combinational controls by one cycle and drives nothing.
  always_comb begin
    state_d = StRun;
    if (mem_busy) begin
      state_d = StHold;
    end else if (raw) begin
      state_d = StRaw;
    end
  end

  // Saturating stall-cycle counter.
  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_ex_v_q   <= 1'b0;
      sb_ex_rd_q  <= '0;
      sb_mem_v_q  <= 1'b0;
      sb_mem_rd_q <= '0;
      sb_wb_v_q   <= 1'b0;
      sb_wb_rd_q  <= '0;
      state_q     <= StRun;
      cnt_q       <= '0;
    end else begin
      sb_ex_v_q   <= sb_ex_v_d;
      sb_ex_rd_q  <= sb_ex_rd_d;
      sb_mem_v_q  <= sb_mem_v_d;
      sb_mem_rd_q <= sb_mem_rd_d;
      sb_wb_v_q   <= sb_wb_v_d;
      sb_wb_rd_q  <= sb_wb_rd_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
    end
  end

  assign hz_state  = state_q;
  assign stall_cnt = cnt_q;

endmodule

// File: doc/raw_hazard_unit.md
Name: raw_hazard_unit

Overview:
- Decode-stage RAW hazard detector for the 5-stage pipeline, which has no forwarding.
- Consumes the per-instruction source-usage flags produced by the opcode match decoders: `id_uses_rs` and `id_match_both` (Rt also read).
- Shadows destination registers of instructions in EX, MEM and WB in a 3-entry scoreboard.
- Drives the IF/ID hold and the ID/EX bubble insert, plus a stall performance counter.

Parameters:
- `REG_W`, 3: register-specifier width (8 GPRs; R0 is a real register, never excluded).
- `CNT_W`, 16: width of the stall-cycle counter.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous reset, active-low.
- `id_valid`  in  1  ID holds a live instruction.
- `id_uses_rs`  in  1  ID instruction reads Rs.
- `id_match_both`  in  1  ID instruction reads both Rs and Rt.
- `id_rs`  in  `REG_W`  Rs specifier.
- `id_rt`  in  `REG_W`  Rt specifier.
- `id_writes_reg`  in  1  ID instruction writes a GPR.
- `id_rd`  in  `REG_W`  destination specifier, already muxed by decode.
- `mem_busy`  in  1  data memory not ready; whole pipe frozen.
- `ex_flush`  in  1  branch/jump resolved taken in EX; ID instruction squashed.
- `stall`  out  1  hold PC and IF/ID register.
- `bubble`  out  1  load NOP into ID/EX.
- `hz_state`  out  2  FSM state: 0 RUN, 1 RAW, 2 HOLD.
- `stall_cnt`  out  `CNT_W`  saturating count of cycles with `stall`=1.

Behaviour:
- Scoreboard entries `sb_ex`, `sb_mem`, `sb_wb`, each {valid, rd}.
- Reset (async, `rst_n`=0): all valid=0, `hz_state`=RUN, `stall_cnt`=0. Outputs `stall`=0 and `bubble`=0 while in reset.
- Hit terms, combinational, zero-cycle latency from ID inputs:
  - `rs_hit` = `id_uses_rs` & any valid entry with rd==`id_rs`.
  - `rt_hit` = `id_match_both` & any valid entry with rd==`id_rt`.
  - `raw` = `id_valid` & !`ex_flush` & (`rs_hit` | `rt_hit`).
- Rt is never compared when `id_match_both`=0, even if specifiers collide.
- `stall` = `raw` | `mem_busy`.
- `bubble` = `raw` & !`mem_busy`.
- Scoreboard update at clock edge:
  - `mem_busy`=1: all entries hold; takes priority over `ex_flush` and `raw`.
  - Otherwise: `sb_wb`<=`sb_mem`, `sb_mem`<=`sb_ex`.
  - `sb_ex`<={1,`id_rd`} only if `id_valid` & `id_writes_reg` & !`raw` & !`ex_flush`; else `sb_ex` valid<=0.
- FSM, registered `hz_state`, evaluated every edge:
  - HOLD if `mem_busy`; else RAW if `raw`; else RUN.
  - `hz_state` lags the combinational outputs by one cycle; status only, not used for control.
- `stall_cnt`: +1 each cycle `stall`=1; saturates at all-ones and never wraps.
- Worst-case RAW stall: 3 cycles (producer in EX); 2 if producer in MEM; 1 if in WB.
- `ex_flush` with `raw`: `stall`=0 and `bubble`=0 that cycle; squashed instruction never enters scoreboard.
- Reset mid-stall: scoreboard cleared, so the next ID instruction sees no hazard.

Optional Feature:
- Macro: `RAW_RF_BYPASS_EN`.
- Defined: register file write-before-read; `sb_wb` excluded from hit terms. Max RAW stall is 2 cycles; `sb_wb` still tracked for debug.
- Undefined: `sb_wb` compared as specified; max RAW stall is 3 cycles.

Test Plan:
- Producer in EX, consumer in ID: ADD R1 issued, then ADD R2,R1,R3 (`id_uses_rs`=1, `id_rs`=1), macro off -> `stall`=`bubble`=1 for exactly 3 cycles, consumer enters EX on 4th; macro on -> 2 cycles, `stall_cnt`=3 or 2 respectively.
- Rt-only collision: producer writes R4; consumer `id_rt`=4, `id_match_both`=0, `id_rs`=2 -> `stall`=0, no bubble; repeat with `id_match_both`=1 -> 3-cycle stall.
- `mem_busy` pulse 2 cycles during a 3-cycle RAW stall -> `bubble`=0 and scoreboard frozen during busy, `hz_state`=HOLD; total `stall` = 5 cycles, `stall_cnt`=5.
- `ex_flush` asserted in first RAW cycle -> `stall`=0 that cycle, `sb_ex` valid=0 next edge, following instruction issues without hazard from the squashed one.
- Force `stall` high 70000 cycles via `mem_busy` -> `stall_cnt` holds 16'hFFFF, no wrap.
- Drop `rst_n` asynchronously mid-RAW stall (between edges) -> `stall`=`bubble`=0 immediately, `hz_state`=RUN, `stall_cnt`=0; after release, dependent consumer issues without stall.
